// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus data-memory access controller with load alignment and store lane steering.
// Optional MEM_ALIGN_CHECK_EN: flag misaligned half/word accesses and suppress the request.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] EX_pc,
  input  logic [31:0] EX_alu_out,
  input  logic [31:0] EX_rs2_out,
  input  logic [4:0]  EX_rd,
  input  logic        EX_regwrite,
  input  logic        EX_mem_read,
  input  logic        EX_mem_write,
  input  logic [2:0]  EX_funct3,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  output logic [31:0] MEM_pc,
  output logic [31:0] MEM_alu_out,
  output logic [4:0]  MEM_rd,
  output logic        MEM_regwrite,
  output logic [31:0] MEM_rdata,
  output logic        mem_stall,
  output logic        MEM_misalign
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        mem_read_p1;
  logic        mem_write_p1;
  logic [2:0]  funct3_p1;
  logic [31:0] rs2_p1;
  logic        capture;
  logic        ex_mem_op;
  logic        ex_misalign;
  logic        resp_ok;

  function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                             input logic [1:0]  addr_lo,
                                             input logic [2:0]  f3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {addr_lo, 3'b000};
    b = shifted[7:0];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b100:  load_align = {24'd0, b};
      3'b101:  load_align = {16'd0, h};
      default: load_align = rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      3'b000:  store_be = 4'b0001 << addr_lo;
      3'b001:  store_be = 4'b0011 << {addr_lo[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'b000:  store_data = {4{rs2[7:0]}};
      3'b001:  store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  assign ex_mem_op = EX_mem_read || EX_mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign ex_misalign = ex_mem_op &&
                       ((((EX_funct3 == 3'b001) || (EX_funct3 == 3'b101)) && EX_alu_out[0]) ||
                        ((EX_funct3 == 3'b010) && (EX_alu_out[1:0] != 2'b00)));
`else
  assign ex_misalign = 1'b0;
`endif

  assign mem_stall = (state == ACCESS) && !dmem_resp;
  assign capture   = load && !mem_stall;
  assign resp_ok   = (state == ACCESS) && dmem_resp;

  // Stage boundary: EX -> MEM capture and access sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      MEM_pc       <= '0;
      MEM_alu_out  <= '0;
      MEM_rd       <= '0;
      MEM_regwrite <= 1'b0;
      MEM_rdata    <= '0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      funct3_p1    <= '0;
      rs2_p1       <= '0;
    end else begin
      if (capture) begin
        if (flush) begin
          state        <= IDLE;
          MEM_pc       <= '0;
          MEM_alu_out  <= '0;
          MEM_rd       <= '0;
          MEM_regwrite <= 1'b0;
          mem_read_p1  <= 1'b0;
          mem_write_p1 <= 1'b0;
          funct3_p1    <= '0;
          rs2_p1       <= '0;
        end else begin
          state        <= (ex_mem_op && !ex_misalign) ? ACCESS : IDLE;
          MEM_pc       <= EX_pc;
          MEM_alu_out  <= EX_alu_out;
          MEM_rd       <= EX_rd;
          MEM_regwrite <= EX_regwrite && !ex_misalign;
          mem_read_p1  <= EX_mem_read && !ex_misalign;
          mem_write_p1 <= EX_mem_write && !ex_misalign;
          funct3_p1    <= EX_funct3;
          rs2_p1       <= EX_rs2_out;
        end
      end else if (resp_ok) begin
        state <= IDLE;
      end
      // Completion uses the op that was in flight, even if a new one is captured this edge
      if (resp_ok && mem_read_p1)
        MEM_rdata <= load_align(dmem_rdata, MEM_alu_out[1:0], funct3_p1);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      MEM_misalign <= 1'b0;
    else if (capture)
      MEM_misalign <= !flush && ex_misalign;
  end
`else
  assign MEM_misalign = 1'b0;
`endif

  assign dmem_read    = (state == ACCESS) && mem_read_p1;
  assign dmem_write   = (state == ACCESS) && mem_write_p1;
  assign dmem_addr    = {MEM_alu_out[31:2], 2'b00};
  assign dmem_wdata   = store_data(funct3_p1, rs2_p1);
  assign dmem_byte_en = mem_read_p1  ? 4'b1111 :
                        mem_write_p1 ? store_be(funct3_p1, MEM_alu_out[1:0]) : 4'b0000;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build; alignment-check branch under MEM_ALIGN_CHECK_EN).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset, load, flush;
  logic [31:0] EX_pc, EX_alu_out, EX_rs2_out;
  logic [4:0]  EX_rd;
  logic        EX_regwrite, EX_mem_read, EX_mem_write;
  logic [2:0]  EX_funct3;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] MEM_pc, MEM_alu_out, MEM_rdata;
  logic [4:0]  MEM_rd;
  logic        MEM_regwrite, mem_stall, MEM_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .load(load), .flush(flush),
    .EX_pc(EX_pc), .EX_alu_out(EX_alu_out), .EX_rs2_out(EX_rs2_out), .EX_rd(EX_rd),
    .EX_regwrite(EX_regwrite), .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write),
    .EX_funct3(EX_funct3), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .MEM_pc(MEM_pc),
    .MEM_alu_out(MEM_alu_out), .MEM_rd(MEM_rd), .MEM_regwrite(MEM_regwrite),
    .MEM_rdata(MEM_rdata), .mem_stall(mem_stall), .MEM_misalign(MEM_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3);
    EX_pc = pc; EX_alu_out = alu; EX_rs2_out = rs2; EX_rd = rd;
    EX_regwrite = rw; EX_mem_read = mr; EX_mem_write = mw; EX_funct3 = f3;
    load = 1'b1;
    tick();
    load = 1'b0;
    flush = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input string tag);
    dmem_rdata = rdata;
    dmem_resp  = 1'b1;
    #1;
    chk({tag, "_stall_at_resp"}, 32'(mem_stall), 32'd0);
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input int waits, input logic [31:0] exp);
    issue(32'h80, addr, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_read"}, 32'(dmem_read), 32'd1);
    chk({tag, "_be"}, 32'(dmem_byte_en), 32'hF);
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_stall_wait"}, 32'(mem_stall), 32'd1);
      tick();
    end
    respond(rdata, tag);
    chk({tag, "_rdata"}, MEM_rdata, exp);
    chk({tag, "_read_done"}, 32'(dmem_read), 32'd0);
    chk({tag, "_regwrite"}, 32'(MEM_regwrite), 32'd1);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; flush = 1'b0;
    EX_pc = '0; EX_alu_out = '0; EX_rs2_out = '0; EX_rd = '0;
    EX_regwrite = 1'b0; EX_mem_read = 1'b0; EX_mem_write = 1'b0; EX_funct3 = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_alu_out", MEM_alu_out, 32'h0);
    chk("rst_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("rst_read", 32'(dmem_read), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_misalign", 32'(MEM_misalign), 32'd0);

    // ALU instruction: no stall, fields visible next cycle
    issue(32'h40, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    chk("add_alu_out", MEM_alu_out, 32'h1234);
    chk("add_rd", 32'(MEM_rd), 32'd5);
    chk("add_pc", MEM_pc, 32'h40);
    chk("add_regwrite", 32'(MEM_regwrite), 32'd1);
    chk("add_stall", 32'(mem_stall), 32'd0);
    chk("add_read", 32'(dmem_read), 32'd0);
    tick();
    chk("add_stall2", 32'(mem_stall), 32'd0);

    // Loads
    run_load("lb",  32'h103, 3'b000, 32'h80FFFFFF, 3, 32'hFFFFFF80);
    run_load("lbu", 32'h103, 3'b100, 32'h80FFFFFF, 0, 32'h00000080);
    run_load("lh",  32'h102, 3'b001, 32'h80011234, 1, 32'hFFFF8001);
    run_load("lhu", 32'h100, 3'b101, 32'h80019234, 0, 32'h00009234);
    run_load("lb1", 32'h101, 3'b000, 32'h11227F44, 0, 32'h0000007F);
    run_load("lw",  32'h104, 3'b010, 32'hCAFEF00D, 2, 32'hCAFEF00D);

    // SH upper half
    issue(32'h90, 32'h202, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    chk("sh_be", 32'(dmem_byte_en), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_write", 32'(dmem_write), 32'd1);
    chk("sh_noread", 32'(dmem_read), 32'd0);
    tick(); tick();
    chk("sh_write_held", 32'(dmem_write), 32'd1);
    chk("sh_stall_held", 32'(mem_stall), 32'd1);
    respond(32'h0, "sh");
    chk("sh_write_done", 32'(dmem_write), 32'd0);

    // SB lane 1 and SW
    issue(32'h94, 32'h301, 32'h123456A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    chk("sb_be", 32'(dmem_byte_en), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    respond(32'h0, "sb");
    issue(32'h98, 32'h308, 32'h01234567, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    chk("sw_be", 32'(dmem_byte_en), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h01234567);
    chk("sw_addr", dmem_addr, 32'h308);
    respond(32'h0, "sw");

    // load held off while stalled
    issue(32'hA0, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
    EX_pc = 32'hBB; EX_alu_out = 32'h999; EX_rd = 5'd3; EX_mem_read = 1'b0;
    load = 1'b1;
    tick(); tick();
    chk("hold_alu_out", MEM_alu_out, 32'h400);
    chk("hold_rd", 32'(MEM_rd), 32'd9);
    chk("hold_pc", MEM_pc, 32'hA0);
    chk("hold_read", 32'(dmem_read), 32'd1);
    load = 1'b0;
    respond(32'h55AA55AA, "hold");
    chk("hold_rdata", MEM_rdata, 32'h55AA55AA);
    chk("hold_alu_after", MEM_alu_out, 32'h400);

    // flush captures a bubble
    flush = 1'b1;
    issue(32'hC0, 32'h500, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    chk("flush_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("flush_read", 32'(dmem_read), 32'd0);
    chk("flush_alu_out", MEM_alu_out, 32'h0);
    chk("flush_stall", 32'(mem_stall), 32'd0);

    // reset in the middle of an access
    issue(32'hD0, 32'h604, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010);
    chk("mid_read", 32'(dmem_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_read", 32'(dmem_read), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_pc", MEM_pc, 32'h0);
    chk("mid_rst_addr", dmem_addr, 32'h0);
    chk("mid_rst_rdata", MEM_rdata, 32'h0);
    chk("mid_rst_be", 32'(dmem_byte_en), 32'h0);
    dmem_rdata = 32'hFFFFFFFF; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    chk("late_resp_rdata", MEM_rdata, 32'h0);
    chk("late_resp_read", 32'(dmem_read), 32'd0);

    // misaligned word load
    issue(32'hE0, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag", 32'(MEM_misalign), 32'd1);
    chk("mis_read", 32'(dmem_read), 32'd0);
    chk("mis_regwrite", 32'(MEM_regwrite), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    issue(32'hE4, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    chk("mis_cleared", 32'(MEM_misalign), 32'd0);
`else
    chk("mis_flag", 32'(MEM_misalign), 32'd0);
    chk("mis_addr", dmem_addr, 32'h100);
    chk("mis_read", 32'(dmem_read), 32'd1);
    respond(32'h89ABCDEF, "mis");
    chk("mis_rdata", MEM_rdata, 32'h89ABCDEF);
    chk("mis_regwrite", 32'(MEM_regwrite), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
